hand_packet_deframer: RTL and testbench

- Receive-side stage on the camera-1 board, directly downstream of the byte-level UART receiver.
- Consumes the byte stream sent by the camera-2 board: a sync preamble of 0xFF bytes followed by a 6-byte payload. Rebuilds the two 12-bit (x,y) hand coordinates (top, bottom).
- Presents the coordinates atomically with a one-cycle valid pulse. Tracks good-frame and error counts.

---
 rtl/hand_packet_deframer.sv | 147 ++++++++++++++
 tb/tb_hand_packet_deframer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hand_packet_deframer.sv
// rtl/hand_packet_deframer.sv - rebuilds two 12-bit (x,y) hand coordinates from a 0xFF-preambled UART byte stream
// Optional range rejection of committed frames: HAND_DEFRAMER_RANGE_CHECK_EN
module hand_packet_deframer #(
  parameter int SYNC_COUNT     = 3,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int MAX_X          = 1023,
  parameter int MAX_Y          = 767
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        byte_valid_in,
  input  logic [7:0]  byte_in,
  output logic [11:0] hand_x_top_out,
  output logic [11:0] hand_y_top_out,
  output logic [11:0] hand_x_bot_out,
  output logic [11:0] hand_y_bot_out,
  output logic        coords_valid_out,
  output logic        synced_out,
  output logic [15:0] frame_count_out,
  output logic [7:0]  error_count_out
);

  localparam int SW = $clog2(SYNC_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SYNC_FULL = SW'(SYNC_COUNT);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {HUNT = 1'b0, PAYLOAD = 1'b1} state_t;

  state_t        state, state_next;
  logic [SW-1:0] sync_cnt;
  logic [2:0]    idx;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    shadow [0:4];
  logic [11:0]   cand_xt, cand_yt, cand_xb, cand_yb;
  logic          is_sync_byte, arm, frame_done, timeout, range_ok;

  // b5 is consumed straight from the bus so the commit lands on the edge that samples it
  assign cand_xt = {shadow[0], shadow[2][7:4]};
  assign cand_yt = {shadow[2][3:0], shadow[1]};
  assign cand_xb = {shadow[3], byte_in[7:4]};
  assign cand_yb = {byte_in[3:0], shadow[4]};

  assign is_sync_byte = (byte_in == 8'hFF);
  assign arm = (state == HUNT) && byte_valid_in && !is_sync_byte && (sync_cnt == SYNC_FULL);

`ifdef HAND_DEFRAMER_RANGE_CHECK_EN
  localparam logic [11:0] MAX_X_L = 12'(MAX_X);
  localparam logic [11:0] MAX_Y_L = 12'(MAX_Y);
  assign range_ok = (cand_xt <= MAX_X_L) && (cand_xb <= MAX_X_L) &&
                    (cand_yt <= MAX_Y_L) && (cand_yb <= MAX_Y_L);
`else
  // limits are irrelevant without range checking; the expression is constant true
  assign range_ok = (MAX_X >= 0) || (MAX_Y >= 0);
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    timeout    = 1'b0;
    case (state)
      HUNT: begin
        if (arm) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        // an arriving byte always beats an expiring idle counter
        if (byte_valid_in) begin
          if (idx == 3'd5) begin
            state_next = HUNT;
            frame_done = 1'b1;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          state_next = HUNT;
          timeout    = 1'b1;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_comb begin
    synced_out = (state == PAYLOAD);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_cnt         <= '0;
      idx              <= '0;
      idle_cnt         <= '0;
      for (int i = 0; i < 5; i++) shadow[i] <= '0;
      hand_x_top_out   <= '0;
      hand_y_top_out   <= '0;
      hand_x_bot_out   <= '0;
      hand_y_bot_out   <= '0;
      coords_valid_out <= 1'b0;
      frame_count_out  <= '0;
      error_count_out  <= '0;
    end else begin
      coords_valid_out <= 1'b0;
      if (state == HUNT) begin
        idle_cnt <= '0;
        if (byte_valid_in) begin
          if (is_sync_byte) begin
            if (sync_cnt != SYNC_FULL) sync_cnt <= sync_cnt + 1'b1;
          end else begin
            sync_cnt <= '0;
            if (arm) begin
              shadow[0] <= byte_in;
              idx       <= 3'd1;
            end
          end
        end
      end else begin
        sync_cnt <= '0;
        if (byte_valid_in) begin
          idle_cnt <= '0;
          if (idx != 3'd5) begin
            shadow[idx] <= byte_in;
            idx         <= idx + 1'b1;
          end
        end else if (!timeout) begin
          idle_cnt <= idle_cnt + 1'b1;
        end else begin
          idle_cnt <= '0;
        end
      end

      if (frame_done && range_ok) begin
        hand_x_top_out   <= cand_xt;
        hand_y_top_out   <= cand_yt;
        hand_x_bot_out   <= cand_xb;
        hand_y_bot_out   <= cand_yb;
        coords_valid_out <= 1'b1;
        frame_count_out  <= frame_count_out + 1'b1;
      end

      if ((timeout || (frame_done && !range_ok)) && (error_count_out != 8'hFF))
        error_count_out <= error_count_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_hand_packet_deframer.sv
// tb/tb_hand_packet_deframer.sv - scoreboard bench for hand_packet_deframer
module tb_hand_packet_deframer;

  localparam int T = 300;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        byte_valid_in;
  logic [7:0]  byte_in;
  logic [11:0] hand_x_top_out, hand_y_top_out, hand_x_bot_out, hand_y_bot_out;
  logic        coords_valid_out, synced_out;
  logic [15:0] frame_count_out;
  logic [7:0]  error_count_out;

  hand_packet_deframer #(.SYNC_COUNT(3), .TIMEOUT_CYCLES(T), .MAX_X(1023), .MAX_Y(767)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .byte_valid_in(byte_valid_in), .byte_in(byte_in),
    .hand_x_top_out(hand_x_top_out), .hand_y_top_out(hand_y_top_out),
    .hand_x_bot_out(hand_x_bot_out), .hand_y_bot_out(hand_y_bot_out),
    .coords_valid_out(coords_valid_out), .synced_out(synced_out),
    .frame_count_out(frame_count_out), .error_count_out(error_count_out)
  );

  always #5 clk_in = ~clk_in;

  longint cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] xt, yt, xb, yb;
    logic [15:0] fc;
    longint      cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0, n_err = 0;
  int          exp_fc = 0, exp_ec = 0, exp_pulses = 0, seen_pulses = 0;
  logic [11:0] last_xt = 0, last_yt = 0, last_xb = 0, last_yb = 0;
  logic        prev_valid = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit frame_accepted(input logic [11:0] xt, yt, xb, yb);
`ifdef HAND_DEFRAMER_RANGE_CHECK_EN
    return (xt <= 1023) && (xb <= 1023) && (yt <= 767) && (yb <= 767);
`else
    return 1'b1;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid_in = 1'b1;
    byte_in       = b;
    @(negedge clk_in);
    byte_valid_in = 1'b0;
    repeat (gap) @(negedge clk_in);
  endtask

  task automatic send_frame(input logic [11:0] xt, yt, xb, yb, input int pre, gmin, gmax);
    logic [7:0] b [6];
    exp_t e;
    b[0] = xt[11:4];
    b[1] = yt[7:0];
    b[2] = {xt[3:0], yt[11:8]};
    b[3] = xb[11:4];
    b[4] = yb[7:0];
    b[5] = {xb[3:0], yb[11:8]};
    for (int i = 0; i < pre; i++) send_byte(8'hFF, $urandom_range(gmax, gmin));
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        if (frame_accepted(xt, yt, xb, yb)) begin
          exp_fc++;
          e.xt = xt; e.yt = yt; e.xb = xb; e.yb = yb;
          e.fc = exp_fc[15:0];
          e.cyc = cyc + 1;
          sb.push_back(e);
          exp_pulses++;
          last_xt = xt; last_yt = yt; last_xb = xb; last_yb = yb;
        end else if (exp_ec < 255) begin
          exp_ec++;
        end
      end
      send_byte(b[i], $urandom_range(gmax, gmin));
    end
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_x_top"}, hand_x_top_out, last_xt);
    chk({tag, "_y_top"}, hand_y_top_out, last_yt);
    chk({tag, "_x_bot"}, hand_x_bot_out, last_xb);
    chk({tag, "_y_bot"}, hand_y_bot_out, last_yb);
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (coords_valid_out) begin
        exp_t e;
        seen_pulses++;
        chk("pulse_width", prev_valid, 0);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("x_top", hand_x_top_out, e.xt);
          chk("y_top", hand_y_top_out, e.yt);
          chk("x_bot", hand_x_bot_out, e.xb);
          chk("y_bot", hand_y_bot_out, e.yb);
          chk("frame_count", frame_count_out, e.fc);
          chk("commit_latency", cyc, e.cyc);
        end
      end
      prev_valid = coords_valid_out;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    byte_valid_in = 1'b0;
    byte_in = 8'h00;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_synced", synced_out, 0);
    chk("rst_valid", coords_valid_out, 0);
    chk("rst_fc", frame_count_out, 0);
    chk("rst_ec", error_count_out, 0);
    chk_held("rst");

    // nominal frame 12 34 5A 20 80 31
    send_frame(12'h125, 12'hA34, 12'h203, 12'h180, 3, 0, 0);
    repeat (2) @(negedge clk_in);
    chk("nominal_fc", frame_count_out, 1);
    chk("nominal_synced", synced_out, 0);
    chk_held("nominal");

    // short preamble is silently ignored
    send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h5A, 0);
    send_byte(8'h20, 0); send_byte(8'h80, 0); send_byte(8'h31, 1);
    chk("short_synced", synced_out, 0);
    chk("short_ec", error_count_out, 0);
    send_frame(12'h7E1, 12'h2C3, 12'h0A5, 12'hF00, 3, 0, 1);

    // 0xFF bytes inside the payload are data
    send_frame(12'h100, 12'hFFF, 12'h000, 12'h3FF, 3, 0, 0);
    repeat (2) @(negedge clk_in);
    chk_held("ffdata");

    // timeout after three payload bytes
    send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    chk("to_synced_mid", synced_out, 1);
    repeat (T - 1) @(negedge clk_in);
    chk("to_synced_edge", synced_out, 1);
    @(negedge clk_in);
    exp_ec++;
    chk("to_synced_after", synced_out, 0);
    chk("to_ec", error_count_out, exp_ec);
    chk_held("to_hold");
    send_frame(12'h3C3, 12'h1E1, 12'h0F0, 12'h2D2, 3, 0, 2);

    // every gap exactly one short of the timeout
    send_frame(12'h456, 12'h789, 12'hABC, 12'hDEF, 3, T - 1, T - 1);
    repeat (2) @(negedge clk_in);
    chk("gapmax_ec", error_count_out, exp_ec);

    for (int f = 0; f < 50; f++) begin
      int gmax;
      gmax = ($urandom_range(9, 0) == 0) ? T - 1 : 6;
      send_frame(12'($urandom_range(12'hFEF, 0)), 12'($urandom_range(12'hFFF, 0)),
                 12'($urandom_range(12'hFEF, 0)), 12'($urandom_range(12'hFFF, 0)),
                 $urandom_range(5, 3), 0, gmax);
    end
    repeat (3) @(negedge clk_in);
    chk("random_fc", frame_count_out, exp_fc);
    chk("random_pulses", seen_pulses, exp_pulses);
    chk("random_ec", error_count_out, exp_ec);

    // asynchronous reset in the middle of a payload
    send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    #2 rst_in = 1'b1;
    #1;
    exp_fc = 0; exp_ec = 0;
    last_xt = 0; last_yt = 0; last_xb = 0; last_yb = 0;
    sb.delete();
    chk_held("arst");
    chk("arst_synced", synced_out, 0);
    chk("arst_fc", frame_count_out, 0);
    chk("arst_ec", error_count_out, 0);
    chk("arst_valid", coords_valid_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    send_frame(12'h321, 12'h123, 12'h0FE, 12'h2EF, 4, 0, 3);

    // out-of-range x: rejected only when range checking is built in
    send_frame(12'h400, 12'h100, 12'h010, 12'h020, 3, 0, 2);
    repeat (3) @(negedge clk_in);
    chk("range_fc", frame_count_out, exp_fc);
    chk("range_ec", error_count_out, exp_ec);
    chk_held("range");

    repeat (5) @(negedge clk_in);
    chk("sb_drained", sb.size(), 0);
    chk("total_pulses", seen_pulses, exp_pulses);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
